// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fixed instruction encodings, IF state type and IF/ID payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: data + valid, async reset, hold, and synchronous flush (flush wins).
module if_id_reg #(
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic [DW-1:0] d_data,
  input  logic          d_valid,
  output logic [DW-1:0] q_data,
  output logic          q_valid
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (!hold) begin
      data_d  = d_data;
      valid_d = d_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, next-PC mux, RUN/HALTED FSM, feeding the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        id_instruction,
  output logic [31:0]        id_pc,
  output logic               id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt,
`endif
  output logic               halted
);

  logic [31:0] pc_q, pc_d;
  if_state_t   state_q, state_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus4;
  logic        fetch_load;
  if_id_t      fetch_data, id_data;

  assign pc_plus4   = pc_q + 32'd4;
  assign fetch_load = !redirect_en && !stall && (state_q == RUN);

  // Next PC / state; redirect outranks stall, stall outranks fetch.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fetch_data = '{instruction: imem_rdata, pc_plus4: pc_plus4};
    if (state_q == HALTED) begin
      fetch_data = '{instruction: NOP_INSTR, pc_plus4: 32'h0};
    end
    if (redirect_en) begin
      pc_d    = redirect_pc & ~32'h3;
      state_d = RUN;
    end else if (fetch_load) begin
      if (imem_rdata == HALT_WORD) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_plus4;
      end
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Halted cycles load a bubble, so the halt word reaches ID exactly once.
  if_id_reg #(.DW($bits(if_id_t))) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (stall),
    .flush   (redirect_en),
    .d_data  (fetch_data),
    .d_valid (state_q == RUN),
    .q_data  (id_data),
    .q_valid (id_valid)
  );

  assign imem_addr      = pc_q[IMEM_AW+1:2];
  assign id_instruction = id_data.instruction;
  assign id_pc          = id_data.pc_plus4;
  assign halted         = halted_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if ((stall || redirect_en) && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
